// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - turns a debounced button level into press/release/auto-repeat events
module button_event_gen #(
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int TW            = 26,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             db_in,
  input  logic             enable,
  input  logic             count_clr,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             repeat_pulse,
  output logic             long_press,
  output logic [CNT_W-1:0] event_count
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          db_q;
  logic          rise;
  logic          fall;
  logic          press_ev;
  logic          repeat_ev;
  logic          release_ev;

  assign rise = db_in & ~db_q;
  assign fall = ~db_in & db_q;

  // A release always wins over a timer expiry landing on the same cycle.
  always_comb begin
    press_ev   = 1'b0;
    repeat_ev  = 1'b0;
    release_ev = 1'b0;
    if (enable) begin
      case (state)
        IDLE: press_ev = rise;
        HOLD: begin
          release_ev = fall;
          repeat_ev  = ~fall && (timer == HOLD_LAST);
        end
        REPEAT: begin
          release_ev = fall;
          repeat_ev  = ~fall && (timer == REPEAT_LAST);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      db_q          <= 1'b0;
      state         <= IDLE;
      timer         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      long_press    <= 1'b0;
      event_count   <= '0;
    end else begin
      db_q          <= db_in;
      press_pulse   <= press_ev;
      release_pulse <= release_ev;
      repeat_pulse  <= repeat_ev;

      if (!enable) begin
        state      <= IDLE;
        timer      <= '0;
        long_press <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            timer <= '0;
            if (press_ev) state <= HOLD;
          end
          HOLD: begin
            if (release_ev) begin
              state <= IDLE;
              timer <= '0;
            end else if (repeat_ev) begin
              state      <= REPEAT;
              long_press <= 1'b1;
              timer      <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          REPEAT: begin
            if (release_ev) begin
              state      <= IDLE;
              long_press <= 1'b0;
              timer      <= '0;
            end else if (repeat_ev) begin
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end

      if (count_clr)
        event_count <= '0;
      else if (press_ev || repeat_ev)
        event_count <= event_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// tb/tb_button_event_gen.sv - directed and random checks of button_event_gen against an age-based model
module tb_button_event_gen;
  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int CW   = 4;
  localparam int TW   = 4;

  logic          clk;
  logic          n_reset;
  logic          db_in;
  logic          enable;
  logic          count_clr;
  logic          press_pulse;
  logic          release_pulse;
  logic          repeat_pulse;
  logic          long_press;
  logic [CW-1:0] event_count;

  int passed;
  int failed;
  int total;

  // Model: a press is tracked by its age in cycles since the press edge.
  bit m_prev, m_active, m_press, m_rel, m_rep, m_long;
  int m_age, m_cnt;

  button_event_gen #(
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .TW(TW), .CNT_W(CW)
  ) dut (
    .clk(clk), .n_reset(n_reset), .db_in(db_in), .enable(enable),
    .count_clr(count_clr), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse),
    .long_press(long_press), .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_active = 0; m_press = 0; m_rel = 0; m_rep = 0; m_long = 0;
    m_age = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit db, input bit en, input bit clr);
    m_press = 0; m_rel = 0; m_rep = 0;
    if (!en) begin
      m_active = 0;
      m_long   = 0;
    end else if (!m_active) begin
      if (db && !m_prev) begin
        m_press  = 1;
        m_active = 1;
        m_age    = 0;
      end
    end else begin
      m_age++;
      if (!db && m_prev) begin
        m_rel    = 1;
        m_active = 0;
        m_long   = 0;
      end else begin
        m_long = (m_age >= HOLD);
        m_rep  = (m_age >= HOLD) && ((m_age - HOLD) % REP == 0);
      end
    end
    if (clr) m_cnt = 0;
    else if (m_press || m_rep) m_cnt = (m_cnt + 1) % (1 << CW);
    m_prev = db;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".press"},   press_pulse,   m_press);
    chk({tag, ".release"}, release_pulse, m_rel);
    chk({tag, ".repeat"},  repeat_pulse,  m_rep);
    chk({tag, ".long"},    long_press,    m_long);
    chk({tag, ".count"},   event_count,   m_cnt);
  endtask

  task automatic step(input bit db, input bit en, input bit clr, input string tag);
    db_in = db; enable = en; count_clr = clr;
    @(posedge clk);
    model_edge(db, en, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    int reps;
    int run_left;
    bit rdb;
    passed = 0; failed = 0; total = 0;
    n_reset = 1'b0; db_in = 1'b0; enable = 1'b1; count_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.press", press_pulse, 0);
    chk("reset.long", long_press, 0);
    chk("reset.count", event_count, 0);
    n_reset = 1'b1;
    step(0, 1, 0, "idle");

    // Short press
    step(1, 1, 0, "short");
    chk("short.press_at_1", press_pulse, 1);
    step(1, 1, 0, "short");
    step(1, 1, 0, "short");
    step(0, 1, 0, "short");
    chk("short.release_at_1", release_pulse, 1);
    chk("short.count", event_count, 1);
    step(0, 1, 0, "short");

    // Long hold of 20 cycles: repeats 8, 12 and 16 cycles after the press
    reps = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, "long");
      if (repeat_pulse === 1'b1) begin
        reps++;
        chk("long.repeat_slot", ((i == 8) || (i == 12) || (i == 16)), 1);
      end
      if (i == 8) chk("long.long_rises", long_press, 1);
      if (i == 7) chk("long.long_before", long_press, 0);
    end
    chk("long.repeat_total", reps, 3);
    chk("long.count", event_count, 5);
    step(0, 1, 0, "long");
    chk("long.release", release_pulse, 1);
    chk("long.long_drops", long_press, 0);
    step(0, 1, 0, "long");

    // Release on the hold-expiry cycle
    for (int i = 0; i < 8; i++) step(1, 1, 0, "expiry");
    step(0, 1, 0, "expiry");
    chk("expiry.release", release_pulse, 1);
    chk("expiry.no_repeat", repeat_pulse, 0);
    chk("expiry.no_long", long_press, 0);
    step(0, 1, 0, "expiry");
    step(1, 1, 0, "expiry");
    chk("expiry.idle_press", press_pulse, 1);
    step(0, 1, 0, "expiry");

    // Wrap and clear
    step(0, 1, 1, "wrap");
    for (int i = 0; i < 17; i++) begin
      step(1, 1, 0, "wrap");
      step(0, 1, 0, "wrap");
    end
    chk("wrap.count", event_count, 1);
    step(1, 1, 1, "clr");
    chk("clr.press", press_pulse, 1);
    chk("clr.count", event_count, 0);
    step(0, 1, 0, "clr");

    // Enable gating mid-REPEAT
    for (int i = 0; i < 12; i++) step(1, 1, 0, "gate");
    step(1, 0, 0, "gate");
    chk("gate.long_off", long_press, 0);
    chk("gate.no_release", release_pulse, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, "gate");
    step(0, 1, 0, "gate");
    chk("gate.no_release_after", release_pulse, 0);
    step(1, 1, 0, "gate");
    chk("gate.fresh_press", press_pulse, 1);
    step(0, 1, 0, "gate");

    // Async reset mid-REPEAT, between clock edges
    for (int i = 0; i < 11; i++) step(1, 1, 0, "areset");
    #2;
    n_reset = 1'b0;
    #1;
    chk("areset.long", long_press, 0);
    chk("areset.repeat", repeat_pulse, 0);
    chk("areset.count", event_count, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    step(1, 0, 0, "areset");
    for (int i = 0; i < 3; i++) step(1, 1, 0, "areset");
    step(0, 1, 0, "areset");
    chk("areset.no_release", release_pulse, 0);
    step(1, 1, 0, "areset");
    chk("areset.new_press", press_pulse, 1);
    step(0, 1, 0, "areset");

    // Random runs of presses with occasional enable drops and clears
    rdb = 0;
    run_left = 0;
    for (int i = 0; i < 800; i++) begin
      if (run_left == 0) begin
        rdb = ~rdb;
        run_left = rdb ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 6));
      end
      run_left--;
      step(rdb, ($urandom_range(0, 49) != 0), ($urandom_range(0, 39) == 0), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Sits directly downstream of the button debouncer and consumes its clean, debounced level.
- Converts that level into single-cycle command events for the 4-bit computer's front-panel control logic:
  - press pulse,
  - release pulse,
  - hold-to-repeat (auto-repeat) pulses,
  - long-press flag,
  - wrapping event counter.

Parameters:
- HOLD_CYCLES, 50000000, cycles the button must stay pressed before long-press/auto-repeat starts (0.5 s at 100 MHz); legal range >= 2.
- REPEAT_CYCLES, 10000000, cycles between successive repeat pulses once in auto-repeat (0.1 s); legal range >= 2.
- TW, 26, timer width; must hold max(HOLD_CYCLES, REPEAT_CYCLES) - 1.
- CNT_W, 8, event counter width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- n_reset  in  1  reset, asynchronous, active-low.
- db_in  in  1  debounced button level from the debouncer; 1 = pressed.
- enable  in  1  event generation enable; 0 holds the FSM in IDLE.
- count_clr  in  1  synchronous clear of event_count.
- press_pulse  out  1  one-cycle pulse on press.
- release_pulse  out  1  one-cycle pulse on release.
- repeat_pulse  out  1  one-cycle pulse at hold threshold and each repeat interval.
- long_press  out  1  level; high while the button is held past HOLD_CYCLES.
- event_count  out  CNT_W  count of press_pulse plus repeat_pulse events, modulo 2^CNT_W.

Behaviour:
- Reset (n_reset = 0, asynchronous):
  - db_q = 0, state = IDLE, timer = 0.
  - All pulse outputs = 0, long_press = 0, event_count = 0.
  - Reset asserted mid-hold aborts the hold with no release_pulse.
- Edge detection:
  - db_q registers db_in every cycle, regardless of enable.
  - rise = db_in & ~db_q; fall = ~db_in & db_q.
- Output timing:
  - All outputs are registered.
  - A pulse is high for the cycle immediately after the clock edge at which its condition was detected (latency 1 from db_in change to pulse).
  - Pulse outputs default to 0 every cycle.
- FSM states are IDLE, HOLD and REPEAT.
  - IDLE: timer = 0. On rise (with enable = 1): press_pulse = 1, go to HOLD.
  - HOLD: timer increments each cycle.
    - fall: release_pulse = 1, timer = 0, go to IDLE.
    - Otherwise, when timer == HOLD_CYCLES-1: repeat_pulse = 1, long_press = 1, timer = 0, go to REPEAT.
  - REPEAT: timer increments each cycle.
    - fall: release_pulse = 1, long_press = 0, timer = 0, go to IDLE.
    - Otherwise, when timer == REPEAT_CYCLES-1: repeat_pulse = 1, timer = 0.
  - fall has priority over timer expiry in the same cycle; no repeat_pulse is emitted on that cycle.
- enable = 0:
  - Synchronously forces IDLE, timer = 0, long_press = 0, no pulses.
  - No release_pulse is generated for an in-progress press.
  - Because db_q keeps tracking, a button already held when enable rises produces no press_pulse; a fresh rise is required.
- event_count:
  - Increments by 1 on each cycle where press_pulse or repeat_pulse is being registered high.
  - Wraps from 2^CNT_W-1 to 0.
  - count_clr has priority: count becomes 0 that cycle even if an event is registered.
- Timer arithmetic:
  - Unsigned, width TW.
  - Never exceeds the active threshold minus 1.
  - No overflow path exists for legal parameters.

Test Plan:
- Bench uses HOLD_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4, enable=1.
- Short press: db_in high 3 cycles then low -> press_pulse 1 cycle after rise; release_pulse 1 cycle after fall; no repeat_pulse; long_press stays 0; event_count=1.
- Long hold: db_in high 20 cycles -> press_pulse at t+1; repeat_pulse at t+9, t+13, t+17; long_press high from t+9 until 1 cycle after fall; event_count=4.
- Release on expiry cycle: fall coincides with timer==7 in HOLD -> release_pulse only, no repeat_pulse, long_press stays 0, state IDLE.
- Wrap and clear:
  - 17 short presses -> event_count=1 (wrapped through 15 to 0).
  - count_clr asserted together with a press -> event_count=0.
- Enable gating: hold button, drop enable mid-REPEAT -> long_press 0 next cycle, no release_pulse; raise enable while still held -> no press_pulse until release and a new press.
- Async reset: assert n_reset=0 mid-REPEAT between clock edges -> all outputs 0 immediately; after deassert with db_in high -> no press_pulse until a new rise.
